// File: rtl/rom_read_arbiter_pkg.sv
// Shared constants and helpers for the round-robin ROM read arbiter.
package rom_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 7;

  // Width of a requester index; N_REQ is at least 2, so this is never zero.
  function automatic int id_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester, ROM and response signals of the ROM read arbiter.
// slave is the arbiter side; master is the client/ROM side.
interface rom_read_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;

  modport slave (
    input  req_valid, req_addr, rom_data,
    output req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_addr, rom_data,
    input  req_ready, rom_addr, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rom_read_arbiter_rr_arbiter.sv
// Purely combinational rotating-priority encoder: first valid at or after ptr wins.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int ID_W = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);

  int idx;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_grant) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (valid[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = ID_W'(idx);
          any_grant  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among N_REQ requesters.
// Define ROM_ARB_OUTREG_EN to register the response outputs once more (latency T+2).
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                clk,
  input logic                reset,
  rom_read_arbiter_if.slave  bus
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0]   ptr;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_grant;
  logic              grant_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] held_addr;
  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .valid     (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // No grants are issued while reset is held, so req_ready reads zero then.
  assign grant_ok      = any_grant & ~reset;
  assign bus.req_ready = grant_ok ? grant : '0;
  assign sel_addr      = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign bus.rom_addr  = grant_ok ? sel_addr : held_addr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      held_addr <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
    end else begin
      s1_valid <= grant_ok;
      if (grant_ok) begin
        ptr       <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        held_addr <= sel_addr;
        s1_id     <= grant_idx;
      end
    end
  end

`ifdef ROM_ARB_OUTREG_EN
  logic              s2_valid;
  logic [ID_W-1:0]   s2_id;
  logic [DATA_W-1:0] s2_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_data  <= s1_valid ? bus.rom_data : '0;
    end
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_data  = s2_data;
`else
  assign bus.rsp_valid = s1_valid;
  assign bus.rsp_id    = s1_id;
  assign bus.rsp_data  = s1_valid ? bus.rom_data : '0;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a registered-read ROM model.
module tb_rom_read_arbiter;

`ifdef ROM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  logic [6:0] rom_mem [16];

  rom_read_arbiter_if #(.N_REQ(4), .ADDR_W(4), .DATA_W(7)) bus ();

  rom_read_arbiter #(.N_REQ(4), .ADDR_W(4), .DATA_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  function automatic logic [6:0] rom_word(input int a);
    return 7'((a * 5 + 3) % 128);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [15:0] a);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = a;
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input int id, input int addr);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
    if (v) begin
      check({tag, "_id"},   32'(bus.rsp_id),   32'(id));
      check({tag, "_data"}, 32'(bus.rsp_data), 32'(rom_word(addr)));
    end else begin
      check({tag, "_data0"}, 32'(bus.rsp_data), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = rom_word(i);
    bus.rom_data  = '0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    reset         = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_addr",  32'(bus.rom_addr),  32'd0);
    check_rsp("rst_rsp", 1'b0, 0, 0);
    check("rst_id",    32'(bus.rsp_id),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request from requester 1 at address 5
    step(4'b0010, 16'h0050);
    check("t1_ready", 32'(bus.req_ready), 32'b0010);
    check("t1_addr",  32'(bus.rom_addr),  32'd5);
    for (int j = 1; j <= LAT; j++) begin
      step(4'b0000, 16'h0000);
      check_rsp("t1_rsp", j == LAT, 1, 5);
    end

    // All valid after reset: strict rotation 0,1,2,3,0,1,2,3
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8 + LAT; k++) begin
      if (k < 8) begin
        step(4'b1111, 16'h3210);
        check("t2_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
        check("t2_addr",  32'(bus.rom_addr),  32'(k % 4));
      end else begin
        step(4'b0000, 16'h3210);
      end
      if (k >= LAT) check_rsp("t2_rsp", 1'b1, (k - LAT) % 4, (k - LAT) % 4);
      else          check_rsp("t2_rsp", 1'b0, 0, 0);
    end
    step(4'b0000, 16'h0000);
    check_rsp("t2_idle", 1'b0, 0, 0);

    // Requesters 1 and 3 with ptr=2: grants 3, 1, 3
    step(4'b0010, 16'h0070);
    check("t3_pre", 32'(bus.req_ready), 32'b0010);
    step(4'b1010, 16'hA0B0);
    check("t3_g3a", 32'(bus.req_ready), 32'b1000);
    check("t3_a3a", 32'(bus.rom_addr),  32'hA);
    step(4'b1010, 16'hA0B0);
    check("t3_g1",  32'(bus.req_ready), 32'b0010);
    check("t3_a1",  32'(bus.rom_addr),  32'hB);
    step(4'b1010, 16'hA0B0);
    check("t3_g3b", 32'(bus.req_ready), 32'b1000);
    for (int j = 0; j < LAT + 1; j++) step(4'b0000, 16'h0000);

    // Idle gap after a read of address 9
    step(4'b0001, 16'h0009);
    check("t4_addr", 32'(bus.rom_addr), 32'd9);
    for (int j = 1; j <= LAT + 2; j++) begin
      step(4'b0000, 16'h0000);
      check("t4_hold",  32'(bus.rom_addr),  32'd9);
      check("t4_ready", 32'(bus.req_ready), 32'd0);
      check_rsp("t4_rsp", j == LAT, 0, 9);
    end

    // Asynchronous reset mid-cycle with a response pending
    step(4'b0001, 16'h0002);
    check("t5_grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #2;
    bus.req_valid = 4'b0000;
    check("t5_pend", 32'(bus.rsp_valid), 32'(LAT == 1));
    reset = 1'b1;
    #1;
    check_rsp("t5_rst", 1'b0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(4'b1111, 16'h3210);
    check("t5_first", 32'(bus.req_ready), 32'b0001);
    check("t5_addr",  32'(bus.rom_addr),  32'd0);
    step(4'b0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Round-robin arbiter that shares one synchronous single-port ROM (BRAM-backed, registered read, 1-cycle latency) between N_REQ requesters. It accepts one read per cycle through a valid/ready handshake, drives the ROM address and returns the ROM word tagged with the requester ID. It sits between the display/lookup clients and the ROM instance; the ROM itself stays outside the block.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 4, ROM address width
- DATA_W, 7, ROM word width
- ID_W, $clog2(N_REQ), requester ID width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester read request
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_ready  out  N_REQ  one-hot grant; a read is accepted when req_valid[i] && req_ready[i]
- rom_addr  out  ADDR_W  address to the ROM
- rom_data  in  DATA_W  ROM registered output, valid one cycle after the address
- rsp_valid  out  1  response strobe, one cycle per accepted read
- rsp_id  out  ID_W  requester index of the response
- rsp_data  out  DATA_W  ROM word

## Operation
- Priority pointer ptr (ID_W bits). Each cycle, the granted requester is the first i with req_valid[i] set, searching ptr, ptr+1, … mod N_REQ.
- req_ready is combinational: it is one-hot for the granted i and all-zero when no req_valid is set. A ready bit is never raised without its valid.
- On a grant: rom_addr = req_addr[grant] in the same cycle, and ptr <= (grant+1) mod N_REQ at the clock edge. With no grant, ptr holds.
- rom_addr is registered-mux free. It is combinational from the grant, and holds its last granted value when idle (a registered copy is muxed in) to avoid needless BRAM toggling.
- Requesters hold req_addr stable while req_valid is set and req_ready is low. Dropping valid before ready is legal; the request is withdrawn.
- Response path: a granted cycle sets rsp_valid and rsp_id (the grant index) at the next edge. rsp_data = rsp_valid ? rom_data : 0.
- Responses have no backpressure. Consumers must sample on rsp_valid.
- Throughput is one read per cycle. Back-to-back grants to the same requester occur only when no other requester is valid.
- Simultaneous valid on all lines: the service order is strictly rotating from ptr, and no requester waits more than N_REQ-1 grants.
- Reset values: ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, held address register=0 (so rom_addr=0 when idle), req_ready=0.
- Reset mid-operation: in-flight responses are discarded, and rsp_valid drops asynchronously. After reset release, requester 0 has top priority.

## Timing
- Grant and rom_addr in cycle T, combinational from req_valid/req_addr/ptr.
- rsp_valid/rsp_id/rsp_data in cycle T+1 (T+2 with the output register, see below).
- The critical path is the req_valid → rotating priority encode → address mux → rom_addr, and it must close at the ROM clock.

## Configuration
- ROM_ARB_OUTREG_EN defined: adds a pipeline stage. rsp_valid, rsp_id and rsp_data are registered again, giving latency T+2. The registered rsp_data resets to 0 and loads rom_data only when the stage-1 valid is set, otherwise 0. Throughput is unchanged.
- ROM_ARB_OUTREG_EN undefined: latency T+1, and rsp_data is the gated rom_data as above.

## Structure
- Package rom_arb_pkg holds the default constants (N_REQ_DEF, ADDR_W_DEF, DATA_W_DEF) and a helper function for ID width.
- Sub-module rr_arbiter(N_REQ) takes valid, ptr and yields the one-hot grant plus the binary grant index and any_grant. It is purely combinational. ptr lives in the top.
- The top contains the address mux, the held address register, ptr, and the response pipeline.

## Test plan
- Single request: req_valid=4'b0010, addr1=4'h5 → req_ready=4'b0010 and rom_addr=5 in the same cycle. Next cycle: rsp_valid=1, rsp_id=1, rsp_data=ROM[5].
- All four valid for 8 cycles after reset, addr_i=i → grants 0,1,2,3,0,1,2,3. Responses follow one cycle later with matching IDs and ROM[i].
- Requesters 1 and 3 valid with ptr=2 → grant 3, then 1, then 3. Requester 1 is never starved.
- Idle gap after a read of addr 9 → rom_addr stays 9, rsp_valid=0, rsp_data=0.
- Reset asserted asynchronously mid-cycle with a response pending → rsp_valid=0 immediately. After release with all valid, the first grant is 0.
- With ROM_ARB_OUTREG_EN, repeat test 2 → identical sequence shifted by one cycle, and rsp_data=0 whenever rsp_valid=0.
